systolic_array_mm: RTL and testbench
====================================

// Module: systolic_array_mm
// PURPOSE
//  Parametrised output-stationary ROWSxCOLS systolic matrix multiplier computing C = A*B.
//  A is ROWSxK and B is KxCOLS, with K set per job by k_len.
//  Operands stream in one K-slice per handshake beat and are skewed internally.
//  Results drain one C row per beat over a valid/ready port. Sits between operand buffers and result memory.
// PARAMETERS
//  ROWS    3   PE rows (rows of A / C)
//  COLS    3   PE columns (columns of B / C)
//  DATA_W  16  signed operand width
//  ACC_W   32  signed accumulator/result width; must be >= 2*DATA_W
//  K_MAX   16  max inner dimension; KW = $clog2(K_MAX+1)
// PORTS
//  clk        in   1            clock
//  rst        in   1            synchronous active-high reset
//  start      in   1            begin job; sampled only in IDLE
//  k_len      in   KW           inner dimension, sampled with start; values > K_MAX are clamped to K_MAX
//  in_valid   in   1            operand beat valid
//  in_ready   out  1            operand beat accepted when in_valid&&in_ready
//  a_col      in   ROWS*DATA_W  A[i][k] at bits i*DATA_W +: DATA_W
//  b_row      in   COLS*DATA_W  B[k][j] at bits j*DATA_W +: DATA_W
//  res_valid  out  1            result row valid
//  res_ready  in   1            result row consumed
//  res_row    out  $clog2(ROWS) index of row on res_data
//  res_data   out  COLS*ACC_W   C[res_row][j] at bits j*ACC_W +: ACC_W
//  busy       out  1            high in any state other than IDLE
//  done       out  1            one-cycle pulse after the final row handshake
// BEHAVIOUR
//  Reset: state=IDLE; in_ready, res_valid, busy, done = 0; res_row = 0; res_data = 0;
//   all PE accumulators and skew registers = 0. Reset mid-job aborts the job; no done pulse.
//  FSM IDLE->LOAD->FLUSH->DRAIN->IDLE.
//   IDLE:  start=1 clears accumulators and skew registers, latches k_len, then goes to LOAD.
//          If k_len==0, goes directly to DRAIN; all results are 0.
//   LOAD:  in_ready=1. Each accepted beat pushes a_col/b_row into the skew lines.
//          Leaves after the k_len-th beat.
//   FLUSH: in_ready=0 for exactly ROWS+COLS-1 cycles, then DRAIN.
//   DRAIN: res_valid=1 for rows 0..ROWS-1 in order.
//          res_row/res_data are held stable while res_valid&&!res_ready.
//          After the last row handshake: done=1 for one cycle, state=IDLE.
//  Skew: row i of A is delayed i cycles; column j of B is delayed j cycles.
//   Skew lines and PE east/south registers shift every cycle in LOAD and FLUSH.
//   A cycle without an accepted beat injects zero at all edges (a bubble).
//   Bubbles do not disturb alignment, so in_valid gaps are legal at any point.
//  PE(i,j) each cycle: acc += sext(a*b). The product is a signed DATA_W x DATA_W product
//   at 2*DATA_W bits, sign-extended to ACC_W. Operands pass east/south with 1-cycle latency.
//  Arithmetic: accumulation wraps modulo 2^ACC_W (default build).
//  start while busy is ignored. in_valid outside LOAD is ignored (in_ready=0).
//  Min latency from start to first res_valid: k_len + ROWS + COLS cycles (no bubbles, k_len > 0).
// CONFIGURATION
//  SA_SATURATE_EN defined: each accumulate clamps to
//   [-2^(ACC_W-1), 2^(ACC_W-1)-1] and saturation is sticky within a job.
//   Adds output sat_flag (1 bit), valid with res_valid: high if any element of that row saturated.
//  Undefined: accumulation wraps; sat_flag does not exist.
// STRUCTURE
//  Package sa_pkg: state enum sa_state_t {IDLE, LOAD, FLUSH, DRAIN};
//   localparam helpers for KW and FLUSH_CYC=ROWS+COLS-1; saturating-add function.
//  Sub-module sa_pe: one MAC processing element
//   (clk, rst, clr, en, a_in, b_in, a_out, b_out, acc), instantiated ROWSxCOLS via generate.
//  Top module holds the FSM, k counter, flush counter, skew shift registers and drain mux.
// TESTING
//  1) 3x3, k_len=5, A=B=identity-padded ramp, no stalls -> C matches golden model;
//     first res_valid 11 cycles after start.
//  2) k_len=4, random signed operands, in_valid 50% random
//     -> C equals the golden model; the bubbles do not change the result.
//  3) res_ready low for 7 cycles on row 1 -> res_row/res_data are stable;
//     rows are delivered 0,1,2 exactly once; done pulses once.
//  4) k_len=0 -> 3 rows of zeros; no in_ready; done follows the third handshake.
//  5) rst asserted mid-LOAD after 2 beats; new job k_len=2
//     -> outputs 0 during reset; new results are uncontaminated; no done for the aborted job.
//  6) A=B=0x7FFF everywhere, ACC_W=32, k_len=16 -> wrapped sum by default;
//     with SA_SATURATE_EN, 0x7FFFFFFF and sat_flag=1.

Source files
------------

// File: rtl/sa_pkg.sv
// Shared types and helpers for the systolic matrix multiplier.
// Build option SA_SATURATE_EN selects saturating accumulation.
package sa_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FLUSH,
    DRAIN
  } sa_state_t;

  function automatic int sa_kw(input int k_max);
    return $clog2(k_max + 1);
  endfunction

  function automatic int sa_flush_cyc(input int rows, input int cols);
    return rows + cols - 1;
  endfunction

  // Signed add overflow: operands agree in sign, sum does not.
  function automatic logic sa_ovf(
    input logic a_s,
    input logic b_s,
    input logic s_s
  );
    return (a_s == b_s) && (s_s != a_s);
  endfunction

endpackage

// File: rtl/systolic_array_mm_pe.sv
// One multiply-accumulate cell of the output-stationary array.
// SA_SATURATE_EN clamps the accumulator and adds a sticky sat bit.
module sa_pe
  import sa_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
`ifdef SA_SATURATE_EN
  output logic              sat,
`endif
  output logic [ACC_W-1:0]  acc
);

  logic signed [2*DATA_W-1:0] prod;
  logic [ACC_W-1:0]           prod_x;
  logic [ACC_W-1:0]           sum;
  logic [ACC_W-1:0]           acc_nxt;

  assign prod   = $signed(a_in) * $signed(b_in);
  assign prod_x = ACC_W'(prod);
  assign sum    = acc + prod_x;

`ifdef SA_SATURATE_EN
  logic ovf;

  assign ovf = sa_ovf(acc[ACC_W-1], prod_x[ACC_W-1],
                      sum[ACC_W-1]);

  always_comb begin
    acc_nxt = sum;
    if (ovf) begin
      acc_nxt = {acc[ACC_W-1], {(ACC_W-1){~acc[ACC_W-1]}}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sat <= 1'b0;
    end else if (en) begin
      sat <= sat | ovf;
    end
  end
`else
  assign acc_nxt = sum;
`endif

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      a_out <= '0;
      b_out <= '0;
      acc   <= '0;
    end else if (en) begin
      a_out <= a_in;
      b_out <= b_in;
      acc   <= acc_nxt;
    end
  end

endmodule

// File: rtl/systolic_array_mm.sv
// Output-stationary ROWSxCOLS systolic multiplier, C = A*B.
// SA_SATURATE_EN adds saturating accumulation and sat_flag.
module systolic_array_mm
  import sa_pkg::*;
#(
  parameter  int ROWS   = 3,
  parameter  int COLS   = 3,
  parameter  int DATA_W = 16,
  parameter  int ACC_W  = 32,
  parameter  int K_MAX  = 16,
  localparam int KW     = sa_kw(K_MAX),
  localparam int RW     = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [KW-1:0]          k_len,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ROWS*DATA_W-1:0] a_col,
  input  logic [COLS*DATA_W-1:0] b_row,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [RW-1:0]          res_row,
  output logic [COLS*ACC_W-1:0]  res_data,
`ifdef SA_SATURATE_EN
  output logic                   sat_flag,
`endif
  output logic                   busy,
  output logic                   done
);

  localparam int FLUSH_CYC = sa_flush_cyc(ROWS, COLS);
  localparam int FW        = $clog2(FLUSH_CYC + 1);

  sa_state_t     state;
  logic [KW-1:0] k_lat;
  logic [KW-1:0] k_cnt;
  logic [KW-1:0] k_clamp;
  logic [FW-1:0] f_cnt;
  logic          accept;
  logic          clr;
  logic          shift;

  assign k_clamp = (k_len > KW'(K_MAX)) ? KW'(K_MAX) : k_len;
  assign accept  = in_valid && in_ready;
  assign clr     = (state == IDLE) && start;
  assign shift   = (state == LOAD) || (state == FLUSH);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      res_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      res_row   <= '0;
      k_lat     <= '0;
      k_cnt     <= '0;
      f_cnt     <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            k_lat   <= k_clamp;
            k_cnt   <= '0;
            busy    <= 1'b1;
            res_row <= '0;
            if (k_clamp == '0) begin
              state     <= DRAIN;
              res_valid <= 1'b1;
            end else begin
              state    <= LOAD;
              in_ready <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (accept) begin
            k_cnt <= k_cnt + KW'(1);
            if (k_cnt == k_lat - KW'(1)) begin
              state    <= FLUSH;
              in_ready <= 1'b0;
              f_cnt    <= '0;
            end
          end
        end
        FLUSH: begin
          f_cnt <= f_cnt + FW'(1);
          if (f_cnt == FW'(FLUSH_CYC - 1)) begin
            state     <= DRAIN;
            res_valid <= 1'b1;
            res_row   <= '0;
          end
        end
        DRAIN: begin
          if (res_ready) begin
            if (res_row == RW'(ROWS - 1)) begin
              state     <= IDLE;
              res_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              res_row   <= '0;
            end else begin
              res_row <= res_row + RW'(1);
            end
          end
        end
      endcase
    end
  end

  // Edge inputs: a cycle without an accepted beat injects a zero bubble.
  logic [DATA_W-1:0] a_src [ROWS];
  logic [DATA_W-1:0] b_src [COLS];

  always_comb begin
    for (int i = 0; i < ROWS; i++) begin
      a_src[i] = accept ? a_col[i*DATA_W +: DATA_W] : '0;
    end
    for (int j = 0; j < COLS; j++) begin
      b_src[j] = accept ? b_row[j*DATA_W +: DATA_W] : '0;
    end
  end

  logic [DATA_W-1:0] a_h [ROWS][COLS+1];
  logic [DATA_W-1:0] b_v [ROWS+1][COLS];
  logic [ACC_W-1:0]  acc_m [ROWS][COLS];

  for (genvar gi = 0; gi < ROWS; gi++) begin : g_askew
    if (gi == 0) begin : g_d0
      assign a_h[gi][0] = a_src[gi];
    end else begin : g_dn
      logic [DATA_W-1:0] sr [gi];
      always_ff @(posedge clk) begin
        if (rst || clr) begin
          for (int n = 0; n < gi; n++) sr[n] <= '0;
        end else if (shift) begin
          sr[0] <= a_src[gi];
          for (int n = 1; n < gi; n++) sr[n] <= sr[n-1];
        end
      end
      assign a_h[gi][0] = sr[gi-1];
    end
  end

  for (genvar gj = 0; gj < COLS; gj++) begin : g_bskew
    if (gj == 0) begin : g_d0
      assign b_v[0][gj] = b_src[gj];
    end else begin : g_dn
      logic [DATA_W-1:0] sr [gj];
      always_ff @(posedge clk) begin
        if (rst || clr) begin
          for (int n = 0; n < gj; n++) sr[n] <= '0;
        end else if (shift) begin
          sr[0] <= b_src[gj];
          for (int n = 1; n < gj; n++) sr[n] <= sr[n-1];
        end
      end
      assign b_v[0][gj] = sr[gj-1];
    end
  end

`ifdef SA_SATURATE_EN
  logic sat_m [ROWS][COLS];
`endif

  for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
    for (genvar gj = 0; gj < COLS; gj++) begin : g_col
      sa_pe #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
      ) u_pe (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .en    (shift),
        .a_in  (a_h[gi][gj]),
        .b_in  (b_v[gi][gj]),
        .a_out (a_h[gi][gj+1]),
        .b_out (b_v[gi+1][gj]),
`ifdef SA_SATURATE_EN
        .sat   (sat_m[gi][gj]),
`endif
        .acc   (acc_m[gi][gj])
      );
    end
  end

  // Accumulators are frozen outside LOAD/FLUSH, so a plain mux holds stable.
  always_comb begin
    res_data = '0;
    for (int j = 0; j < COLS; j++) begin
      res_data[j*ACC_W +: ACC_W] = acc_m[res_row][j];
    end
  end

`ifdef SA_SATURATE_EN
  always_comb begin
    sat_flag = 1'b0;
    for (int j = 0; j < COLS; j++) begin
      sat_flag = sat_flag | sat_m[res_row][j];
    end
  end
`endif

endmodule

// File: tb/tb_systolic_array_mm.sv
// Directed bench for systolic_array_mm (3x3, 16-bit operands, 32-bit acc).
// Builds with or without SA_SATURATE_EN.
module tb_systolic_array_mm;

  localparam int ROWS = 3;
  localparam int COLS = 3;
  localparam int DW   = 16;
  localparam int AW   = 32;
  localparam int KM   = 16;
  localparam int KW   = 5;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic [KW-1:0]        k_len;
  logic                 in_valid;
  logic                 in_ready;
  logic [ROWS*DW-1:0]   a_col;
  logic [COLS*DW-1:0]   b_row;
  logic                 res_valid;
  logic                 res_ready;
  logic [1:0]           res_row;
  logic [COLS*AW-1:0]   res_data;
  logic                 busy;
  logic                 done;
`ifdef SA_SATURATE_EN
  logic                 sat_flag;
`endif

  systolic_array_mm dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .k_len     (k_len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_col     (a_col),
    .b_row     (b_row),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_row   (res_row),
    .res_data  (res_data),
`ifdef SA_SATURATE_EN
    .sat_flag  (sat_flag),
`endif
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic signed [DW-1:0] A [ROWS][KM];
  logic signed [DW-1:0] B [KM][COLS];

  logic [COLS*AW-1:0] got_data [ROWS];
  logic [1:0]         got_row  [ROWS];
  bit                 got_sat  [ROWS];
  int                 got_n;
  int                 done_cnt;
  bit                 done_after;
  bit                 stable_bad;
  int                 lat;
  bit                 saw_ready;

  function automatic logic [COLS*AW-1:0] gold_row(input int i, input int k);
    logic [COLS*AW-1:0] r;
    longint s;
    r = '0;
    for (int j = 0; j < COLS; j++) begin
      s = 0;
      for (int t = 0; t < k; t++) begin
        s += longint'(A[i][t]) * longint'(B[t][j]);
      end
      r[j*AW +: AW] = s[AW-1:0];
    end
    return r;
  endfunction

  task automatic drive_beat(input int s);
    for (int i = 0; i < ROWS; i++) a_col[i*DW +: DW] = A[i][s];
    for (int j = 0; j < COLS; j++) b_row[j*DW +: DW] = B[s][j];
  endtask

  // Starts a job and feeds beats until res_valid or a cycle budget expires.
  task automatic run_job(input int k, input int pct);
    int sent;
    sent      = 0;
    saw_ready = 0;
    start     = 1'b1;
    k_len     = KW'(k);
    lat       = 0;
    @(negedge clk);
    lat++;
    start = 1'b0;
    while (!res_valid && lat < 500) begin
      if (in_ready) saw_ready = 1;
      in_valid = 1'b0;
      if (sent < k && sent < KM && in_ready) begin
        if (pct == 0 || $urandom_range(99) >= pct) begin
          in_valid = 1'b1;
          drive_beat(sent);
          sent++;
        end
      end
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
  endtask

  // Collects result rows; optionally stalls res_ready on one row.
  task automatic drain(input int stall_row, input int stall_n);
    int left;
    bit snapped;
    logic [1:0] snap_r;
    logic [COLS*AW-1:0] snap_d;
    left       = stall_n;
    snapped    = 0;
    got_n      = 0;
    done_cnt   = 0;
    stable_bad = 0;
    snap_r     = '0;
    snap_d     = '0;
    for (int t = 0; t < 300 && got_n < ROWS; t++) begin
      res_ready = 1'b0;
      if (res_valid) begin
        if (res_row == 2'(stall_row) && left > 0) begin
          if (!snapped) begin
            snap_r  = res_row;
            snap_d  = res_data;
            snapped = 1;
          end else if (res_row !== snap_r || res_data !== snap_d) begin
            stable_bad = 1;
          end
          left--;
        end else begin
          res_ready       = 1'b1;
          got_data[got_n] = res_data;
          got_row[got_n]  = res_row;
`ifdef SA_SATURATE_EN
          got_sat[got_n]  = sat_flag;
`else
          got_sat[got_n]  = 1'b0;
`endif
          got_n++;
        end
      end
      if (done) done_cnt++;
      @(negedge clk);
    end
    res_ready  = 1'b0;
    done_after = done;
    if (done) done_cnt++;
    repeat (3) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; k_len = '0; in_valid = 1'b0;
    res_ready = 1'b0; a_col = '0; b_row = '0;
    repeat (3) @(negedge clk);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL rst_res_valid got=%b exp=0", res_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", done); end
    total++; if (res_row !== 2'd0) begin bad++; $display("FAIL rst_res_row got=%0d exp=0", res_row); end
    total++; if (res_data !== '0) begin bad++; $display("FAIL rst_res_data got=%h exp=0", res_data); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ramp();
    for (int i = 0; i < ROWS; i++)
      for (int t = 0; t < KM; t++) A[i][t] = DW'(i + t + 1);
    for (int t = 0; t < KM; t++)
      for (int j = 0; j < COLS; j++) B[t][j] = (t < 3) ? DW'(t == j) : DW'(t - j);
    run_job(5, 0);
    total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL ramp_timeout got=%b exp=1", res_valid); end
    total++; if (lat != 11) begin bad++; $display("FAIL ramp_latency got=%0d exp=11", lat); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL ramp_busy got=%b exp=1", busy); end
    drain(-1, 0);
    for (int r = 0; r < ROWS; r++) begin
      total++;
      if (got_row[r] !== 2'(r) || got_data[r] !== gold_row(r, 5)) begin
        bad++;
        $display("FAIL ramp_row%0d got=%0d/%h exp=%0d/%h", r, got_row[r], got_data[r], r, gold_row(r, 5));
      end
    end
    total++; if (done_after !== 1'b1 || done_cnt != 1) begin bad++; $display("FAIL ramp_done got=%b/%0d exp=1/1", done_after, done_cnt); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ramp_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_bubbles();
    for (int i = 0; i < ROWS; i++)
      for (int t = 0; t < 4; t++) A[i][t] = DW'(int'($urandom_range(2000)) - 1000);
    for (int t = 0; t < 4; t++)
      for (int j = 0; j < COLS; j++) B[t][j] = DW'(int'($urandom_range(2000)) - 1000);
    run_job(4, 50);
    total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL bub_timeout got=%b exp=1", res_valid); end
    drain(-1, 0);
    for (int r = 0; r < ROWS; r++) begin
      total++;
      if (got_data[r] !== gold_row(r, 4)) begin
        bad++;
        $display("FAIL bub_row%0d got=%h exp=%h", r, got_data[r], gold_row(r, 4));
      end
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < ROWS; i++)
      for (int t = 0; t < 3; t++) A[i][t] = DW'(3 * i - t + 2);
    for (int t = 0; t < 3; t++)
      for (int j = 0; j < COLS; j++) B[t][j] = DW'(j - 2 * t - 1);
    run_job(3, 0);
    drain(1, 7);
    total++; if (stable_bad !== 1'b0) begin bad++; $display("FAIL stall_stable got=%b exp=0", stable_bad); end
    total++; if (got_n != ROWS) begin bad++; $display("FAIL stall_count got=%0d exp=%0d", got_n, ROWS); end
    for (int r = 0; r < ROWS; r++) begin
      total++;
      if (got_row[r] !== 2'(r) || got_data[r] !== gold_row(r, 3)) begin
        bad++;
        $display("FAIL stall_row%0d got=%0d/%h exp=%0d/%h", r, got_row[r], got_data[r], r, gold_row(r, 3));
      end
    end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL stall_done got=%0d exp=1", done_cnt); end
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL stall_extra got=%b exp=0", res_valid); end
  endtask

  task automatic test_k_zero();
    run_job(0, 0);
    total++; if (saw_ready !== 1'b0) begin bad++; $display("FAIL kz_in_ready got=%b exp=0", saw_ready); end
    total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL kz_valid got=%b exp=1", res_valid); end
    drain(-1, 0);
    for (int r = 0; r < ROWS; r++) begin
      total++;
      if (got_row[r] !== 2'(r) || got_data[r] !== '0) begin
        bad++;
        $display("FAIL kz_row%0d got=%0d/%h exp=%0d/0", r, got_row[r], got_data[r], r);
      end
    end
    total++; if (done_after !== 1'b1 || done_cnt != 1) begin bad++; $display("FAIL kz_done got=%b/%0d exp=1/1", done_after, done_cnt); end
  endtask

  task automatic test_reset_mid();
    int dn;
    for (int i = 0; i < ROWS; i++)
      for (int t = 0; t < 4; t++) A[i][t] = DW'(16'h1234 + i);
    for (int t = 0; t < 4; t++)
      for (int j = 0; j < COLS; j++) B[t][j] = DW'(16'h0321 + j);
    start = 1'b1; k_len = KW'(4);
    @(negedge clk);
    start = 1'b0;
    for (int s = 0; s < 2; s++) begin
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_in_ready got=%b exp=1", in_ready); end
      in_valid = 1'b1;
      drive_beat(s);
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    total++; if (in_ready !== 1'b0 || busy !== 1'b0 || res_valid !== 1'b0) begin
      bad++; $display("FAIL mid_rst_ctrl got=%b%b%b exp=000", in_ready, busy, res_valid);
    end
    total++; if (res_data !== '0) begin bad++; $display("FAIL mid_rst_data got=%h exp=0", res_data); end
    @(negedge clk);
    rst = 1'b0;
    dn = 0;
    repeat (5) begin
      @(negedge clk);
      if (done) dn++;
    end
    total++; if (dn != 0) begin bad++; $display("FAIL mid_abort_done got=%0d exp=0", dn); end
    for (int i = 0; i < ROWS; i++)
      for (int t = 0; t < 2; t++) A[i][t] = DW'(i - t + 1);
    for (int t = 0; t < 2; t++)
      for (int j = 0; j < COLS; j++) B[t][j] = DW'(j + t + 2);
    run_job(2, 0);
    drain(-1, 0);
    for (int r = 0; r < ROWS; r++) begin
      total++;
      if (got_data[r] !== gold_row(r, 2)) begin
        bad++;
        $display("FAIL mid_row%0d got=%h exp=%h", r, got_data[r], gold_row(r, 2));
      end
    end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL mid_done got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_clamp();
    for (int i = 0; i < ROWS; i++)
      for (int t = 0; t < KM; t++) A[i][t] = 16'sd1;
    for (int t = 0; t < KM; t++)
      for (int j = 0; j < COLS; j++) B[t][j] = 16'sd1;
    run_job(31, 0);
    drain(-1, 0);
    for (int r = 0; r < ROWS; r++) begin
      total++;
      if (got_data[r] !== {3{32'd16}}) begin
        bad++;
        $display("FAIL clamp_row%0d got=%h exp=%h", r, got_data[r], {3{32'd16}});
      end
    end
  endtask

  task automatic test_sat();
    logic [COLS*AW-1:0] exp_row;
`ifdef SA_SATURATE_EN
    exp_row = {3{32'h7FFF_FFFF}};
`else
    exp_row = {3{32'hFFF0_0010}};
`endif
    for (int i = 0; i < ROWS; i++)
      for (int t = 0; t < KM; t++) A[i][t] = 16'sh7FFF;
    for (int t = 0; t < KM; t++)
      for (int j = 0; j < COLS; j++) B[t][j] = 16'sh7FFF;
    run_job(16, 0);
    drain(-1, 0);
    for (int r = 0; r < ROWS; r++) begin
      total++;
      if (got_data[r] !== exp_row) begin
        bad++;
        $display("FAIL sat_row%0d got=%h exp=%h", r, got_data[r], exp_row);
      end
`ifdef SA_SATURATE_EN
      total++;
      if (got_sat[r] !== 1'b1) begin
        bad++;
        $display("FAIL sat_flag%0d got=%b exp=1", r, got_sat[r]);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_bubbles();
    test_stall();
    test_k_zero();
    test_reset_mid();
    test_clamp();
    test_sat();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
